// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops from load/toggle/set/clear requests, with one tick per update.
// Build option JKDRV_READBACK_EN: verify Q after settling and re-drive on mismatch; otherwise done follows the tick.
`timescale 1ns/1ps

//  state    | meaning
//  S_IDLE   | ready for a request, drive outputs at 0
//  S_DRIVE  | tick high, J/K excitation presented to the bank
//  S_SETTLE | tick and J/K at 0 while the bank output settles
//  S_CHECK  | compare q_fb with the target value, then finish or re-drive
module jk_bank_driver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             tick_out,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam bit P_CFG_OK = (SETTLE_CYCLES >= 1) && (MAX_RETRY >= 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_tick;
  logic             r_done;
  logic             w_accept;
  logic [WIDTH-1:0] w_j_acc;
  logic [WIDTH-1:0] w_k_acc;

  // An illegal parameter set leaves an empty marker scope in the elaborated hierarchy.
  if (!P_CFG_OK) begin : g_cfg_invalid
  end

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign j_out     = r_j;
  assign k_out     = r_k;
  assign tick_out  = r_tick;
  assign done      = r_done;

  always_comb begin
    w_j_acc = '0;
    w_k_acc = '0;
    case (req_mode)
      2'b00: begin
        w_j_acc = req_data & ~q_fb;
        w_k_acc = ~req_data & q_fb;
      end
      2'b01: begin
        w_j_acc = req_data;
        w_k_acc = req_data;
      end
      2'b10: w_j_acc = req_data;
      default: w_k_acc = req_data;
    endcase
  end

`ifdef JKDRV_READBACK_EN
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SCW-1:0] P_SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [RCW-1:0] P_RETRY_MAX   = RCW'(MAX_RETRY);

  logic [WIDTH-1:0] r_expected;
  logic [SCW-1:0]   r_settle_cnt;
  logic [RCW-1:0]   r_retry_cnt;
  logic             r_error;
  logic [WIDTH-1:0] w_expected;

  assign error = r_error;

  always_comb begin
    w_expected = req_data;
    case (req_mode)
      2'b01:   w_expected = q_fb ^ req_data;
      2'b10:   w_expected = q_fb | req_data;
      2'b11:   w_expected = q_fb & ~req_data;
      default: w_expected = req_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_j          <= '0;
      r_k          <= '0;
      r_tick       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_expected   <= '0;
      r_settle_cnt <= '0;
      r_retry_cnt  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_DRIVE;
            r_j         <= w_j_acc;
            r_k         <= w_k_acc;
            r_tick      <= 1'b1;
            r_expected  <= w_expected;
            r_retry_cnt <= '0;
          end
        end
        S_DRIVE: begin
          r_state      <= S_SETTLE;
          r_j          <= '0;
          r_k          <= '0;
          r_tick       <= 1'b0;
          r_settle_cnt <= P_SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (r_settle_cnt == '0) r_state <= S_CHECK;
          else                    r_settle_cnt <= r_settle_cnt - 1'b1;
        end
        S_CHECK: begin
          if (q_fb == r_expected) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_retry_cnt != P_RETRY_MAX) begin
            // Re-drive only the bits that still differ from the target.
            r_retry_cnt <= r_retry_cnt + 1'b1;
            r_j         <= r_expected & ~q_fb;
            r_k         <= ~r_expected & q_fb;
            r_tick      <= 1'b1;
            r_state     <= S_DRIVE;
          end else begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign error = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_k     <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_DRIVE;
            r_j     <= w_j_acc;
            r_k     <= w_k_acc;
            r_tick  <= 1'b1;
          end
        end
        S_DRIVE: begin
          r_state <= S_IDLE;
          r_j     <= '0;
          r_k     <= '0;
          r_tick  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: behavioural JK bank on the falling edge, directed and random requests.
`timescale 1ns/1ps

module tb_jk_bank_driver;
  localparam int W = 8;
  localparam int S = 1;
  localparam int R = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_mode = 2'b00;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] q_fb;
  logic [W-1:0] j_out;
  logic [W-1:0] k_out;
  logic         tick_out;
  logic         busy;
  logic         done;
  logic         error;

  int n_checks = 0;
  int n_fail = 0;

  jk_bank_driver #(.WIDTH(W), .SETTLE_CYCLES(S), .MAX_RETRY(R)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_data(req_data), .q_fb(q_fb), .j_out(j_out), .k_out(k_out),
    .tick_out(tick_out), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Bank model with fault injection: stuck-at-0 bits and bits that miss the first tick of a request.
  logic [W-1:0] bank;
  logic         preload_en = 1'b0;
  logic [W-1:0] preload_val = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] fail_first = '0;
  int           txn_base = 0;
  int           tick_cnt = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;
  int           both_cnt = 0;
  logic [W-1:0] last_j = '0;
  int           exp_done_total = 0;
  int           exp_err_total = 0;

  assign q_fb = bank;

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k, input logic [W-1:0] hold);
    logic [W-1:0] n;
    n = (j & ~q) | (~k & q);
    return (n & ~hold) | (q & hold);
  endfunction

  always @(negedge clock) begin
    if (preload_en) bank <= preload_val;
    else if (tick_out)
      bank <= jk_next(bank, j_out, k_out, (tick_cnt == txn_base) ? fail_first : '0) & ~stuck0;
    if (tick_out) begin
      tick_cnt <= tick_cnt + 1;
      last_j   <= j_out;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_target(input logic [1:0] mode, input logic [W-1:0] d,
                                              input logic [W-1:0] q0);
    case (mode)
      2'b00:   return d;
      2'b01:   return q0 ^ d;
      2'b10:   return q0 | d;
      default: return q0 & ~d;
    endcase
  endfunction

  // J raises bits, K lowers them; toggle drives both on the mask.
  function automatic void ref_excite(input logic [1:0] mode, input logic [W-1:0] d,
                                     input logic [W-1:0] q0, output logic [W-1:0] ej,
                                     output logic [W-1:0] ek);
    ej = '0;
    ek = '0;
    case (mode)
      2'b00: begin ej = d & ~q0; ek = ~d & q0; end
      2'b01: begin ej = d; ek = d; end
      2'b10: ej = d;
      default: ek = d;
    endcase
  endfunction

  task automatic preload(input logic [W-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clock);
    #1;
    preload_en = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Issue one request from an idle DUT and follow it to done/error; returns in the pulse cycle.
  task automatic run_req(input logic [1:0] mode, input logic [W-1:0] data,
                         input int exp_ticks, input bit exp_err);
    logic [W-1:0] q0, tgt, ej, ek;
    int t0, lat, exp_lat;
    q0  = bank;
    tgt = ref_target(mode, data, q0);
    ref_excite(mode, data, q0, ej, ek);
`ifdef JKDRV_READBACK_EN
    exp_lat = exp_ticks * (2 + S);
`else
    exp_lat = 1;
`endif
    chk("ready_before_req", req_ready, 1);
    txn_base  = tick_cnt;
    t0        = tick_cnt;
    req_mode  = mode;
    req_data  = data;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("tick_after_accept", tick_out, 1);
    chk("j_after_accept", j_out, ej);
    chk("k_after_accept", k_out, ek);
    lat = 0;
    while (!done && !error && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("done_pulse", done, !exp_err);
    chk("error_pulse", error, exp_err);
    chk("ticks", tick_cnt - t0, exp_ticks);
    if (!exp_err) chk("bank_value", bank, tgt);
    if (exp_err) exp_err_total++;
    else         exp_done_total++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   m;
    logic [W-1:0] d;
    int t0, n_acc;

    preload(8'h00);
    chk("rst_tick", tick_out, 0);
    chk("rst_j", j_out, 0);
    chk("rst_k", k_out, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Reset in the middle of DRIVE abandons the update.
    req_mode  = 2'b00;
    req_data  = 8'hFF;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("mid_drive_tick", tick_out, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_tick", tick_out, 0);
    chk("async_rst_j", j_out, 0);
    chk("async_rst_k", k_out, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_no_done", done_cnt, 0);
    chk("post_rst_bank", bank, 8'h00);

    preload(8'h0F);
    run_req(2'b00, 8'hA5, 1, 0);

    // Back-to-back: second request accepted in the done cycle of the first.
    preload(8'h00);
    run_req(2'b01, 8'h81, 1, 0);
    chk("ready_in_done_cycle", req_ready & done, 1);
    run_req(2'b10, 8'h10, 1, 0);
    chk("b2b_bank", bank, 8'h91);

    run_req(2'b11, 8'h00, 1, 0);
    run_req(2'b01, 8'h00, 1, 0);

`ifdef JKDRV_READBACK_EN
    preload(8'h00);
    stuck0 = 8'h08;
    run_req(2'b00, 8'h08, R + 1, 1);
    stuck0 = 8'h00;
    preload(8'h00);
    fail_first = 8'h08;
    run_req(2'b00, 8'h08, 2, 0);
    chk("retry_j", last_j, 8'h08);
    fail_first = 8'h00;
`endif

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) preload(W'($urandom));
      m = 2'($urandom_range(0, 3));
      d = W'($urandom);
      run_req(m, d, 1, 0);
    end

    // req_valid held high: one accept per pass through IDLE.
    @(posedge clock);
    #1;
    t0        = tick_cnt;
    req_mode  = 2'b01;
    req_data  = W'($urandom);
    req_valid = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    req_valid = 1'b0;
`ifdef JKDRV_READBACK_EN
    n_acc = 20 / (3 + S);
`else
    n_acc = 20 / 2;
`endif
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clock);
      #1;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("held_valid_accepts", tick_cnt - t0, n_acc);
    exp_done_total += n_acc;

    chk("done_total", done_cnt, exp_done_total);
    chk("error_total", err_cnt, exp_err_total);
    chk("done_error_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Initiator for a bank of `J_K_FLIPFLOP` cells.
- Accepts a register-update request (load / toggle / set / clear) over a valid/ready handshake.
- Converts it into per-bit J/K excitation and a one-cycle tick.
- Reads the bank's Q outputs back and retries or flags an error on mismatch.
- Sits between microcode or control sequencing and any JK-based status/flag register in the ND120 shared logic.

## Interface
Parameters:
- `WIDTH`, 8: bits in the driven flip-flop bank.
- `SETTLE_CYCLES`, 1: cycles between tick and readback compare; must be ≥1.
- `MAX_RETRY`, 2: corrective re-drives before `error`; 0 means the first mismatch errors.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and able to accept.
- `req_mode` in 2: 00 load, 01 toggle mask, 10 set mask, 11 clear mask.
- `req_data` in WIDTH: load value, or bit mask.
- `q_fb` in WIDTH: Q outputs of the flip-flop bank.
- `j_out` out WIDTH: J drive to bank.
- `k_out` out WIDTH: K drive to bank.
- `tick_out` out 1: tick/enable drive to bank.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse, update verified (or issued, without readback).
- `error` out 1: one-cycle pulse, retries exhausted.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- Accept: `req_valid & req_ready` at a rising edge, in IDLE only. `req_ready = (state==IDLE)`.
- On accept, capture `q0 = q_fb` and compute `expected` (WIDTH bits, bitwise):
  - load: `req_data`
  - toggle: `q0 ^ m`
  - set: `q0 | m`
  - clear: `q0 & ~m`
- Excitation registered at accept:
  - load: J = d & ~q0, K = ~d & q0 (only differing bits driven)
  - toggle: J = K = m
  - set: J = m, K = 0
  - clear: J = 0, K = m
- DRIVE, one cycle: `tick_out=1` and J/K held. Next state SETTLE.
- SETTLE, `SETTLE_CYCLES` cycles: `tick_out=0`, J/K forced 0. Next state CHECK.
- CHECK, one cycle: compare `q_fb` against `expected`.
  - Match: pulse `done`, go to IDLE.
  - Mismatch and retry count < `MAX_RETRY`: increment count, re-excite with load rule (target = `expected`, current = `q_fb`), go to DRIVE.
  - Mismatch and count = `MAX_RETRY`: pulse `error`, go to IDLE.
- Requests presented while busy are ignored; they are not queued.
- An all-zero mask still issues a tick with J=K=0, and the request completes with `done`.
- `done` and `error` are never high together.

## Timing
- Reset, asynchronous: state IDLE, `j_out=k_out=0`, `tick_out=0`, `done=error=busy=0`, `req_ready=1`, retry count 0.
- Reset asserted mid-operation: all drive outputs drop to 0 immediately. The update in progress is abandoned, with no done or error.
- Accept at edge E0:
  - `tick_out` high for the cycle E0→E1.
  - SETTLE for E1 to E1+SETTLE_CYCLES.
  - CHECK for one cycle.
  - `done`/`error` high for the cycle following the CHECK edge.
  - With `SETTLE_CYCLES=1`, `done` is high in cycle E3→E4.
- Each retry adds 2+SETTLE_CYCLES cycles.
- `req_ready` is high in the same cycle as the `done`/`error` pulse, so back-to-back acceptance is allowed.
- The bank clocks on the falling edge (default inverted clock enable). `tick_out`, `j_out` and `k_out` are registered and stable across that falling edge.

## Configuration
- Macro `JKDRV_READBACK_EN`.
- Defined: SETTLE/CHECK/retry/error behave as described above.
- Undefined:
  - DRIVE goes directly to IDLE with `done` pulsed in the next cycle (accept at E0 → `done` high E1→E2).
  - `error` is tied 0.
  - `q_fb` is used only for load excitation.
  - No retry counter is implemented.

## Test plan
- Reset: hold `reset_n=0` mid-DRIVE → `tick_out`, `j_out`, `k_out` go 0 asynchronously. After release, `req_ready=1` and no `done`.
- Load 0xA5 with `q_fb`=0x0F → `j_out`=0xA0, `k_out`=0x0A, one tick cycle. Model bank reaches 0xA5 → `done` in cycle E3→E4.
- Toggle mask 0x81 then set 0x10, issued back to back, from 0x00 → bank reaches 0x81 then 0x91. Second request is accepted in the `done` cycle of the first.
- Stuck bit: model holds bit 3 at 0, load 0x08, `MAX_RETRY=2` → three ticks total, then `error` pulse and no `done`.
- Transient fault: bit fails on the first tick only → one retry with `j_out`=0x08, then `done`.
- `req_valid` held high while busy → exactly one accept per IDLE cycle. Without `JKDRV_READBACK_EN` → `done` high E1→E2 and `error` never asserts.
